// File: rtl/bs_accum_pkg.sv
// Shared types and helpers for the bitstream accumulator array.
//   state_e    : window FSM states (idle, accumulating, holding a result)
//   win_last   : window counter value on the final enabled cycle of a window
//   half_scale : bipolar decode offset, half of the window length
package bs_accum_pkg;

   typedef enum logic [1:0] {
      StIdle = 2'd0,
      StAcc  = 2'd1,
      StHold = 2'd2
   } state_e;

   function automatic int unsigned win_last(input int unsigned cwid);
      return (32'd1 << cwid) - 32'd1;
   endfunction

   function automatic int unsigned half_scale(input int unsigned cwid);
      return 32'd1 << (cwid - 32'd1);
   endfunction

endpackage

// File: rtl/bs_accum_lane.sv
// One bitstream lane: ones accumulator plus result register.
// Optional feature macro: BS_ACCUM_BIPOLAR_EN (result = ones - 2^(CWID-1), two's complement).
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   clr_i      : clear the accumulator (start of a window)
//   tick_i     : enabled bitstream cycle, add bit_i into the accumulator
//   load_i     : final enabled cycle, transfer accumulator + bit_i into cnt_o
//   bit_i      : this lane's bitstream bit
//   cnt_o      : decoded result, CWID+1 bits
module bs_accum_lane
   import bs_accum_pkg::*;
#(
   parameter int unsigned CWID = 10
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          clr_i,
   input  logic          tick_i,
   input  logic          load_i,
   input  logic          bit_i,
   output logic [CWID:0] cnt_o
);

   localparam int unsigned OWID = CWID + 1;

`ifdef BS_ACCUM_BIPOLAR_EN
   localparam logic [OWID-1:0] Offset = OWID'(half_scale(CWID));
`else
   localparam logic [OWID-1:0] Offset = '0;
`endif

   logic [OWID-1:0] acc_q, acc_d;
   logic [OWID-1:0] cnt_q, cnt_d;
   logic [OWID-1:0] sum;

   // The final sample is folded in here so the result lands on the same edge.
   assign sum = acc_q + OWID'(bit_i);

   always_comb begin
      acc_d = acc_q;
      cnt_d = cnt_q;
      if (clr_i) begin
         acc_d = '0;
      end else if (tick_i) begin
         acc_d = sum;
      end
      if (load_i) begin
         cnt_d = sum - Offset;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc_q <= '0;
         cnt_q <= '0;
      end else begin
         acc_q <= acc_d;
         cnt_q <= cnt_d;
      end
   end

   assign cnt_o = cnt_q;

endmodule

// File: rtl/bs_accum_array32.sv
// Bitstream decoder: counts ones in SDIM unary streams over a window of 2^CWID enabled cycles.
// A single window counter and FSM are shared; each lane owns its accumulator and result register.
// Optional feature macro: BS_ACCUM_BIPOLAR_EN (bipolar decode, see bs_accum_lane).
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   enable     : bitstream cycle qualifier, low freezes counting
//   start      : begin a window (in idle, or in hold together with outReady)
//   bitIn      : one bitstream bit per lane
//   busy       : window in progress
//   outValid   : cntOut holds a completed window
//   outReady   : downstream accepts the result
//   cntOut     : per-lane result, CWID+1 bits each
module bs_accum_array32
   import bs_accum_pkg::*;
#(
   parameter int unsigned CWID = 10,
   parameter int unsigned SDIM = 32
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      enable,
   input  logic                      start,
   input  logic [SDIM-1:0]           bitIn,
   output logic                      busy,
   output logic                      outValid,
   input  logic                      outReady,
   output logic [SDIM-1:0][CWID:0]   cntOut
);

   localparam logic [CWID-1:0] WinLast = CWID'(win_last(CWID));

   state_e          state_q, state_d;
   logic [CWID-1:0] win_q, win_d;
   logic            clr, tick, load;

   always_comb begin
      state_d = state_q;
      win_d   = win_q;
      clr     = 1'b0;
      tick    = 1'b0;
      load    = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (start) begin
               state_d = StAcc;
               win_d   = '0;
               clr     = 1'b1;
            end
         end
         StAcc: begin
            if (enable) begin
               tick  = 1'b1;
               // Wraps to zero on the terminal sample.
               win_d = win_q + CWID'(1);
               if (win_q == WinLast) begin
                  load    = 1'b1;
                  state_d = StHold;
               end
            end
         end
         StHold: begin
            if (outReady) begin
               if (start) begin
                  state_d = StAcc;
                  win_d   = '0;
                  clr     = 1'b1;
               end else begin
                  state_d = StIdle;
               end
            end
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= StIdle;
         win_q   <= '0;
      end else begin
         state_q <= state_d;
         win_q   <= win_d;
      end
   end

   assign busy     = (state_q == StAcc);
   assign outValid = (state_q == StHold);

   for (genvar j = 0; j < SDIM; j++) begin : g_lane
      bs_accum_lane #(
         .CWID (CWID)
      ) u_lane (
         .clk    (clk),
         .rst_n  (rst_n),
         .clr_i  (clr),
         .tick_i (tick),
         .load_i (load),
         .bit_i  (bitIn[j]),
         .cnt_o  (cntOut[j])
      );
   end

endmodule
